// File: rtl/spi_slave_core.sv
// Mode-0 SPI responder: oversamples sclk/ss_n/mosi in the clk domain and exchanges one DATA_W word per frame.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err pulse and err_cnt counter for aborted frames.
module spi_slave_core #(
    parameter int unsigned       DATA_W        = 32,
    parameter int unsigned       SYNC_STAGES   = 2,
    parameter logic [DATA_W-1:0] UNDERRUN_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              frame_err,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_last;

    logic w_sclk_s;
    logic w_ss_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] w_tx_shift_next;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] w_rx_shift_next;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_bit_cnt_next;
    logic              r_miso;
    logic              w_miso_next;
    logic [DATA_W-1:0] r_rx_data;
    logic [DATA_W-1:0] w_rx_data_next;
    logic              r_rx_valid;
    logic              w_rx_valid_next;
    logic              r_underrun;
    logic              w_underrun_next;

    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic              w_copy_hold;
    logic [DATA_W-1:0] w_reload_word;

    // ss_n synchronisers idle high so a reset never looks like a select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_last <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_last <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_last;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_last;

    assign w_reload_word = r_hold_full ? r_hold : UNDERRUN_WORD;

    // A copy and a new accept never coincide: tx_ready is low whenever the hold is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_copy_hold) begin
            r_hold_full <= 1'b0;
        end else if (tx_valid && !r_hold_full) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tx_shift_next = r_tx_shift;
        w_rx_shift_next = r_rx_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_miso_next     = r_miso;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_underrun_next = 1'b0;
        w_copy_hold     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_miso_next = 1'b0;
                if (!w_ss_s) begin
                    w_state_next    = S_ACTIVE;
                    w_tx_shift_next = w_reload_word;
                    w_miso_next     = w_reload_word[DATA_W-1];
                    w_underrun_next = ~r_hold_full;
                    w_copy_hold     = r_hold_full;
                    w_bit_cnt_next  = '0;
                end
            end
            S_ACTIVE: begin
                if (w_ss_s) begin
                    w_state_next = S_IDLE;
                    w_miso_next  = 1'b0;
                end else if (w_sclk_rise) begin
                    if (r_bit_cnt != CNT_FULL) begin
                        w_rx_shift_next = {r_rx_shift[DATA_W-2:0], w_mosi_s};
                        w_bit_cnt_next  = r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_LAST) begin
                            w_rx_data_next  = {r_rx_shift[DATA_W-2:0], w_mosi_s};
                            w_rx_valid_next = 1'b1;
                        end
                    end
                end else if (w_sclk_fall) begin
                    // The falling edge after the last bit starts the next burst word instead of shifting.
                    if (r_bit_cnt == CNT_FULL) begin
                        w_tx_shift_next = w_reload_word;
                        w_miso_next     = w_reload_word[DATA_W-1];
                        w_underrun_next = ~r_hold_full;
                        w_copy_hold     = r_hold_full;
                        w_bit_cnt_next  = '0;
                    end else begin
                        w_tx_shift_next = {r_tx_shift[DATA_W-2:0], 1'b0};
                        w_miso_next     = r_tx_shift[DATA_W-2];
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_miso     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_tx_shift <= w_tx_shift_next;
            r_rx_shift <= w_rx_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_miso     <= w_miso_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid_next;
            r_underrun <= w_underrun_next;
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = (r_state == S_ACTIVE);
    assign busy     = (r_state == S_ACTIVE);
    assign tx_ready = ~r_hold_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign underrun = r_underrun;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       w_abort;
    logic       r_frame_err;
    logic [7:0] r_err_cnt;

    assign w_abort = (r_state == S_ACTIVE) && w_ss_s
                     && (r_bit_cnt != '0) && (r_bit_cnt != CNT_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_frame_err <= w_abort;
            if (w_abort && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a mode-0 master model at sclk = clk/8 with rx/miso scoreboard queues.
`timescale 1ns/1ps
module tb_spi_slave_core;
    localparam int          HALF     = 4;
    localparam logic [31:0] UNDERRUN = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        ss_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        underrun;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_err;
    logic [7:0]  err_cnt;
    int          fe_cnt = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int un_cnt = 0;
    int frame_no = 0;
    logic [31:0] rx_exp_q[$];
    logic [31:0] rx_got_q[$];
    logic [31:0] miso_exp_q[$];

    always #5 clk = ~clk;

    spi_slave_core #(
        .DATA_W(32),
        .SYNC_STAGES(2),
        .UNDERRUN_WORD(UNDERRUN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sclk(sclk),
        .ss_n(ss_n),
        .mosi(mosi),
        .miso(miso),
        .miso_oe(miso_oe),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .underrun(underrun)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err),
        .err_cnt(err_cnt)
`endif
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_got_q.push_back(rx_data);
        if (underrun === 1'b1) un_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err === 1'b1) fe_cnt++;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    // end_mode: 0 = ss_n rises with the last sclk fall, 1 = keep ss_n low, 2 = stop with sclk high
    task automatic spi_frame(input logic [31:0] word, input int nbits, input int end_mode,
                             output logic [31:0] got, output bit oe_ok);
        got   = '0;
        oe_ok = 1'b1;
        mosi  = word[31];
        ss_n  = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            got = {got[30:0], miso};
            if (miso_oe !== 1'b1) oe_ok = 1'b0;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i == nbits - 1 && end_mode == 2) break;
            sclk = 1'b0;
            if (i == nbits - 1) begin
                if (end_mode == 0) ss_n = 1'b1;
            end else begin
                mosi = word[30-i];
            end
            repeat (HALF) @(negedge clk);
        end
        frame_no++;
        $display("frame %0d: bits=%0d mosi=%h miso=%h", frame_no, nbits, word, got);
    endtask

    task automatic push_tx(input logic [31:0] w, output bit ok);
        ok       = 1'b0;
        tx_data  = w;
        tx_valid = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (tx_ready === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({miso, miso_oe, tx_ready, rx_valid, busy, underrun} !== 6'b001000) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b want=001000", {miso, miso_oe, tx_ready, rx_valid, busy, underrun});
        end
        n_cmp++;
        if (rx_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rx_data got=%h want=00000000", rx_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok, oe_ok;
        logic [31:0] got, exp, act;
        int u0;
        push_tx(32'hA5A5_0F0F, ok);
        n_cmp++;
        if (!ok || tx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_preload accepted=%0d tx_ready=%b want accepted=1 tx_ready=0", ok, tx_ready);
        end
        rx_exp_q.push_back(32'h1234_5678);
        miso_exp_q.push_back(32'hA5A5_0F0F);
        u0 = un_cnt;
        spi_frame(32'h1234_5678, 32, 0, got, oe_ok);
        n_cmp++;
        if (miso_oe !== 1'b0 || !oe_ok) begin
            n_bad++;
            $display("FAIL basic_oe in_frame_ok=%0d after=%b want 1/0", oe_ok, miso_oe);
        end
        repeat (2) @(negedge clk);
        exp = miso_exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL basic_miso got=%h want=%h", got, exp);
        end
        n_cmp++;
        if (rx_got_q.size() != 1) begin
            n_bad++;
            $display("FAIL basic_rx_count got=%0d want=1", rx_got_q.size());
        end
        while (rx_exp_q.size() > 0 && rx_got_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            act = rx_got_q.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL basic_rx_data got=%h want=%h", act, exp);
            end
        end
        rx_exp_q.delete();
        rx_got_q.delete();
        n_cmp++;
        if (tx_ready !== 1'b1 || un_cnt - u0 != 0) begin
            n_bad++;
            $display("FAIL basic_tx_ready tx_ready=%b underruns=%0d want 1/0", tx_ready, un_cnt - u0);
        end
    endtask

    task automatic test_underrun();
        bit oe_ok;
        logic [31:0] got, exp, act;
        int u0;
        rx_exp_q.push_back(32'hDEAD_BEEF);
        miso_exp_q.push_back(UNDERRUN);
        u0 = un_cnt;
        spi_frame(32'hDEAD_BEEF, 32, 0, got, oe_ok);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (un_cnt - u0 != 1) begin
            n_bad++;
            $display("FAIL underrun_pulses got=%0d want=1", un_cnt - u0);
        end
        exp = miso_exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL underrun_miso got=%h want=%h", got, exp);
        end
        n_cmp++;
        if (rx_got_q.size() != 1) begin
            n_bad++;
            $display("FAIL underrun_rx_count got=%0d want=1", rx_got_q.size());
        end
        while (rx_exp_q.size() > 0 && rx_got_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            act = rx_got_q.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL underrun_rx_data got=%h want=%h", act, exp);
            end
        end
        rx_exp_q.delete();
        rx_got_q.delete();
    endtask

    task automatic test_burst();
        bit ok, ok2, oe1, oe2;
        logic [31:0] got1, got2, exp, act;
        int u0;
        push_tx(32'h3C3C_C3C3, ok);
        rx_exp_q.push_back(32'h0000_0001);
        rx_exp_q.push_back(32'h0000_0002);
        miso_exp_q.push_back(32'h3C3C_C3C3);
        miso_exp_q.push_back(32'hCAFE_0001);
        u0 = un_cnt;
        ok2 = 1'b0;
        fork
            begin
                spi_frame(32'h0000_0001, 32, 1, got1, oe1);
                spi_frame(32'h0000_0002, 32, 0, got2, oe2);
            end
            begin
                repeat (60) @(negedge clk);
                push_tx(32'hCAFE_0001, ok2);
            end
        join
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok || !ok2 || !oe1 || !oe2 || un_cnt - u0 != 0) begin
            n_bad++;
            $display("FAIL burst_flow push=%0d/%0d oe=%0d/%0d underruns=%0d want 1/1 1/1 0",
                     ok, ok2, oe1, oe2, un_cnt - u0);
        end
        exp = miso_exp_q.pop_front();
        n_cmp++;
        if (got1 !== exp) begin
            n_bad++;
            $display("FAIL burst_miso1 got=%h want=%h", got1, exp);
        end
        exp = miso_exp_q.pop_front();
        n_cmp++;
        if (got2 !== exp) begin
            n_bad++;
            $display("FAIL burst_miso2 got=%h want=%h", got2, exp);
        end
        n_cmp++;
        if (rx_got_q.size() != 2) begin
            n_bad++;
            $display("FAIL burst_rx_count got=%0d want=2", rx_got_q.size());
        end
        while (rx_exp_q.size() > 0 && rx_got_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            act = rx_got_q.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL burst_rx_data got=%h want=%h", act, exp);
            end
        end
        rx_exp_q.delete();
        rx_got_q.delete();
    endtask

    task automatic test_partial();
        bit oe_ok;
        logic [31:0] got;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        int fe0;
        fe0 = fe_cnt;
`endif
        spi_frame(32'hF0F0_1234, 13, 0, got, oe_ok);
        n_cmp++;
        if (miso_oe !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_oe_release miso_oe=%b busy=%b want 0/0", miso_oe, busy);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rx_got_q.size() != 0) begin
            n_bad++;
            $display("FAIL partial_rx_valid got=%0d pulses want=0", rx_got_q.size());
        end
        n_cmp++;
        if (rx_data !== 32'h0000_0002) begin
            n_bad++;
            $display("FAIL partial_rx_hold got=%h want=00000002", rx_data);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        n_cmp++;
        if (fe_cnt - fe0 != 1 || err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL partial_frame_err pulses=%0d err_cnt=%0d want 1/1", fe_cnt - fe0, err_cnt);
        end
`endif
        rx_got_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok, ok2, oe_ok;
        logic [31:0] got, exp, act;
        push_tx(32'h7777_0000, ok);
        spi_frame(32'h5A5A_5A5A, 20, 2, got, oe_ok);
        push_tx(32'h8888_1111, ok2);
        n_cmp++;
        if (!ok || !ok2 || tx_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_setup push=%0d/%0d tx_ready=%b busy=%b want 1/1 0 1", ok, ok2, tx_ready, busy);
        end
        reset = 1'b1;
        sclk  = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        #1;
        n_cmp++;
        if ({miso, miso_oe, tx_ready, rx_valid, busy, underrun} !== 6'b001000 || rx_data !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs ctrl=%b rx_data=%h want 001000 00000000",
                     {miso, miso_oe, tx_ready, rx_valid, busy, underrun}, rx_data);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        rx_got_q.delete();
        rx_exp_q.push_back(32'h0BAD_F00D);
        miso_exp_q.push_back(UNDERRUN);
        spi_frame(32'h0BAD_F00D, 32, 0, got, oe_ok);
        repeat (2) @(negedge clk);
        exp = miso_exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL midreset_miso got=%h want=%h", got, exp);
        end
        n_cmp++;
        if (rx_got_q.size() != 1) begin
            n_bad++;
            $display("FAIL midreset_rx_count got=%0d want=1", rx_got_q.size());
        end
        while (rx_exp_q.size() > 0 && rx_got_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            act = rx_got_q.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL midreset_rx_data got=%h want=%h", act, exp);
            end
        end
        rx_exp_q.delete();
        rx_got_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok, seen, busy_at, oe1, oe2, oe3;
        logic [31:0] g1, g2, g3, exp, act;
        int u0;
        push_tx(32'h1357_9BDF, ok);
        tx_data  = 32'h2468_ACE0;
        tx_valid = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (!ok || tx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_stall accepted=%0d tx_ready=%b want 1/0", ok, tx_ready);
        end
        rx_exp_q.push_back(32'h0F1E_2D3C);
        rx_exp_q.push_back(32'h4B5A_6978);
        rx_exp_q.push_back(32'h8796_A5B4);
        miso_exp_q.push_back(32'h1357_9BDF);
        miso_exp_q.push_back(32'h2468_ACE0);
        miso_exp_q.push_back(UNDERRUN);
        u0      = un_cnt;
        seen    = 1'b0;
        busy_at = 1'b0;
        fork
            spi_frame(32'h0F1E_2D3C, 32, 0, g1, oe1);
            begin
                for (int n = 0; n < 200; n++) begin
                    if (tx_ready === 1'b1) begin
                        seen    = 1'b1;
                        busy_at = busy;
                        @(negedge clk);
                        break;
                    end
                    @(negedge clk);
                end
                tx_valid = 1'b0;
            end
        join
        n_cmp++;
        if (!seen || busy_at !== 1'b1 || tx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_refill seen=%0d busy_at=%b tx_ready_after=%b want 1/1/0", seen, busy_at, tx_ready);
        end
        spi_frame(32'h4B5A_6978, 32, 0, g2, oe2);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_drain tx_ready=%b want=1", tx_ready);
        end
        spi_frame(32'h8796_A5B4, 32, 0, g3, oe3);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (un_cnt - u0 != 1 || !oe1 || !oe2 || !oe3) begin
            n_bad++;
            $display("FAIL hold_underruns got=%0d oe=%0d%0d%0d want 1 111", un_cnt - u0, oe1, oe2, oe3);
        end
        exp = miso_exp_q.pop_front();
        n_cmp++;
        if (g1 !== exp) begin
            n_bad++;
            $display("FAIL hold_miso1 got=%h want=%h", g1, exp);
        end
        exp = miso_exp_q.pop_front();
        n_cmp++;
        if (g2 !== exp) begin
            n_bad++;
            $display("FAIL hold_miso2 got=%h want=%h", g2, exp);
        end
        exp = miso_exp_q.pop_front();
        n_cmp++;
        if (g3 !== exp) begin
            n_bad++;
            $display("FAIL hold_miso3 got=%h want=%h", g3, exp);
        end
        n_cmp++;
        if (rx_got_q.size() != 3) begin
            n_bad++;
            $display("FAIL hold_rx_count got=%0d want=3", rx_got_q.size());
        end
        while (rx_exp_q.size() > 0 && rx_got_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            act = rx_got_q.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL hold_rx_data got=%h want=%h", act, exp);
            end
        end
        rx_exp_q.delete();
        rx_got_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_burst();
        test_partial();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
